// File: rtl/dvp_cam_power_seq.sv
// Power-up and reset sequencer for a DVP camera sensor.
// Order: rails up, XCLK on with reset held, reset released, settle, ready.
module dvp_cam_power_seq #(
   parameter int unsigned T_PWUP_CYC   = 125000,
   parameter int unsigned T_RST_CYC    = 1250,
   parameter int unsigned T_SETTLE_CYC = 2500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cam_start_i,
   input  logic       restart_i,
   output logic       dvp_pwdn_o,
   output logic       dvp_rst_n_o,
   output logic       xclk_en_o,
   output logic       cam_ready_o,
   output logic       seq_done_o,
   output logic [2:0] state_o
);

   // state  | meaning
   // OFF    | sensor powered down, waiting for cam_start_i
   // PWUP   | rails settling, XCLK off, reset held
   // CLKON  | XCLK running, reset held
   // SETTLE | reset released, sensor internal settle
   // READY  | sensor usable; restart_i re-enters CLKON

   localparam int unsigned T_MAX_A = (T_PWUP_CYC > T_RST_CYC) ? T_PWUP_CYC : T_RST_CYC;
   localparam int unsigned T_MAX   = (T_MAX_A > T_SETTLE_CYC) ? T_MAX_A : T_SETTLE_CYC;
   localparam int          CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] PWUP_LAST   = CNT_W'(T_PWUP_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(T_RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_PWUP   = 3'd1,
      S_CLKON  = 3'd2,
      S_SETTLE = 3'd3,
      S_READY  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             done_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_OFF;
         cnt        <= '0;
         seq_done_o <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         seq_done_o <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
      // Dropping the enable wins over restart and over timer expiry.
      if (!cam_start_i) begin
         state_nxt = S_OFF;
      end else begin
         case (state)
            S_OFF:    state_nxt = S_PWUP;
            S_PWUP:
               if (cnt == PWUP_LAST) state_nxt = S_CLKON;
               else                  cnt_nxt   = cnt + CNT_W'(1);
            S_CLKON:
               if (cnt == RST_LAST)  state_nxt = S_SETTLE;
               else                  cnt_nxt   = cnt + CNT_W'(1);
            S_SETTLE:
               if (cnt == SETTLE_LAST) state_nxt = S_READY;
               else                    cnt_nxt   = cnt + CNT_W'(1);
            S_READY:
               if (restart_i) state_nxt = S_CLKON;
            default:  state_nxt = S_OFF;
         endcase
      end
      done_nxt = (state_nxt == S_READY) && (state != S_READY);
   end

   always_comb begin
      dvp_pwdn_o  = 1'b1;
      dvp_rst_n_o = 1'b0;
      xclk_en_o   = 1'b0;
      cam_ready_o = 1'b0;
      case (state)
         S_PWUP:   dvp_pwdn_o = 1'b0;
         S_CLKON: begin
            dvp_pwdn_o = 1'b0;
            xclk_en_o  = 1'b1;
         end
         S_SETTLE: begin
            dvp_pwdn_o  = 1'b0;
            dvp_rst_n_o = 1'b1;
            xclk_en_o   = 1'b1;
         end
         S_READY: begin
            dvp_pwdn_o  = 1'b0;
            dvp_rst_n_o = 1'b1;
            xclk_en_o   = 1'b1;
            cam_ready_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_dvp_cam_power_seq.sv
// Directed bench for dvp_cam_power_seq: short-timer instance (4/3/5)
// plus a minimum-timer instance (1/1/1).
module tb_dvp_cam_power_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cam_start, restart;
   logic       pwdn, rstn_o, xclk_en, ready, done;
   logic [2:0] st;
   logic       cam_start2, restart2;
   logic       pwdn2, rstn_o2, xclk_en2, ready2, done2;
   logic [2:0] st2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dvp_cam_power_seq #(.T_PWUP_CYC(4), .T_RST_CYC(3), .T_SETTLE_CYC(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .cam_start_i(cam_start), .restart_i(restart),
      .dvp_pwdn_o(pwdn), .dvp_rst_n_o(rstn_o), .xclk_en_o(xclk_en),
      .cam_ready_o(ready), .seq_done_o(done), .state_o(st)
   );

   dvp_cam_power_seq #(.T_PWUP_CYC(1), .T_RST_CYC(1), .T_SETTLE_CYC(1)) u_min (
      .clk(clk), .rst_n(rst_n), .cam_start_i(cam_start2), .restart_i(restart2),
      .dvp_pwdn_o(pwdn2), .dvp_rst_n_o(rstn_o2), .xclk_en_o(xclk_en2),
      .cam_ready_o(ready2), .seq_done_o(done2), .state_o(st2)
   );

   // {pwdn, rst_n, xclk_en, ready, seq_done, state[2:0]}
   function automatic logic [7:0] expv(input int s, input logic d);
      logic [3:0] pins;
      logic [2:0] s3;
      s3 = 3'(s);
      case (s)
         0:       pins = 4'b1000;
         1:       pins = 4'b0000;
         2:       pins = 4'b0010;
         3:       pins = 4'b0110;
         4:       pins = 4'b0111;
         default: pins = 4'b1111;
      endcase
      return {pins, d, s3};
   endfunction

   function automatic logic [7:0] obs();
      return {pwdn, rstn_o, xclk_en, ready, done, st};
   endfunction

   function automatic logic [7:0] obs2();
      return {pwdn2, rstn_o2, xclk_en2, ready2, done2, st2};
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_run(input string tag, input int s, input int n);
      repeat (n) begin
         step();
         chk(tag, obs(), expv(s, 1'b0));
      end
   endtask

   task automatic full_seq(input string tag);
      expect_run({tag, "_pwup"}, 1, 4);
      expect_run({tag, "_clkon"}, 2, 3);
      expect_run({tag, "_settle"}, 3, 5);
      step();
      chk({tag, "_ready_done"}, obs(), expv(4, 1'b1));
      expect_run({tag, "_ready"}, 4, 2);
   endtask

   initial begin
      rst_n = 1'b0; cam_start = 1'b0; restart = 1'b0;
      cam_start2 = 1'b0; restart2 = 1'b0;
      #1;
      chk("reset_vals", obs(), expv(0, 1'b0));
      step();
      cam_start = 1'b1;
      step();
      chk("reset_held_start", obs(), expv(0, 1'b0));
      cam_start = 1'b0;
      rst_n = 1'b1;
      expect_run("off_idle", 0, 3);

      // Power-up
      cam_start = 1'b1;
      full_seq("pwrup");

      // Stop mid-SETTLE then start again
      cam_start = 1'b0;
      expect_run("stop_ready", 0, 1);
      cam_start = 1'b1;
      expect_run("s2_pwup", 1, 4);
      expect_run("s2_clkon", 2, 3);
      expect_run("s2_settle", 3, 2);
      cam_start = 1'b0;
      expect_run("stop_settle", 0, 2);
      cam_start = 1'b1;
      full_seq("rerun");

      // Restart from READY
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("rst_clkon", obs(), expv(2, 1'b0));
      expect_run("rst_clkon", 2, 2);
      expect_run("rst_settle", 3, 5);
      step();
      chk("rst_ready_done", obs(), expv(4, 1'b1));
      expect_run("rst_ready", 4, 1);

      // Restart ignored in PWUP and SETTLE
      cam_start = 1'b0;
      expect_run("ign_off", 0, 1);
      cam_start = 1'b1;
      expect_run("ign_pwup", 1, 2);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("ign_pwup_restart", obs(), expv(1, 1'b0));
      expect_run("ign_pwup", 1, 1);
      expect_run("ign_clkon", 2, 3);
      expect_run("ign_settle", 3, 2);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("ign_settle_restart", obs(), expv(3, 1'b0));
      expect_run("ign_settle", 3, 2);
      step();
      chk("ign_ready_done", obs(), expv(4, 1'b1));

      // Stop and restart on the same edge in READY
      cam_start = 1'b0; restart = 1'b1;
      step();
      restart = 1'b0;
      chk("stop_vs_restart", obs(), expv(0, 1'b0));

      // Stop on the PWUP expiry edge
      cam_start = 1'b1;
      expect_run("exp_pwup", 1, 4);
      cam_start = 1'b0;
      expect_run("stop_vs_expiry", 0, 1);

      // Async reset during CLKON
      cam_start = 1'b1;
      expect_run("ar_pwup", 1, 4);
      expect_run("ar_clkon", 2, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_immediate", obs(), expv(0, 1'b0));
      expect_run("async_rst_hold", 0, 2);
      #2 rst_n = 1'b1;
      full_seq("after_rst");

      // Minimum timers: ready three edges after start is sampled
      cam_start2 = 1'b1;
      step(); chk("min_pwup", obs2(), expv(1, 1'b0));
      step(); chk("min_clkon", obs2(), expv(2, 1'b0));
      step(); chk("min_settle", obs2(), expv(3, 1'b0));
      step(); chk("min_ready_done", obs2(), expv(4, 1'b1));
      step(); chk("min_ready", obs2(), expv(4, 1'b0));
      restart2 = 1'b1;
      step();
      restart2 = 1'b0;
      chk("min_restart_clkon", obs2(), expv(2, 1'b0));
      step(); chk("min_restart_settle", obs2(), expv(3, 1'b0));
      step(); chk("min_restart_done", obs2(), expv(4, 1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
